// File: rtl/math_game_pkg.sv
// Shared encodings and helpers for the mental-arithmetic game core.
package math_game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_SHOW   = 3'd1,
    PH_BLANK  = 3'd2,
    PH_ANSWER = 3'd3,
    PH_REVEAL = 3'd4
  } phase_e;

  localparam logic [2:0] PHASE_IDLE   = 3'd0;
  localparam logic [2:0] PHASE_SHOW   = 3'd1;
  localparam logic [2:0] PHASE_BLANK  = 3'd2;
  localparam logic [2:0] PHASE_ANSWER = 3'd3;
  localparam logic [2:0] PHASE_REVEAL = 3'd4;

  // Wrong-answer LED pattern, alternating with LSB=1; truncated to LED_W.
  localparam logic [31:0] LED_WRONG_PATTERN = 32'h5555_5555;

  // Feedback is lfsr[MSB] ^ lfsr[tap]. Width 8 has no maximal two-tap form,
  // so it uses the longest-period two-tap choice.
  function automatic int unsigned lfsr_tap(input int unsigned width);
    case (width)
      3:       return 1;
      4:       return 2;
      5:       return 2;
      6:       return 4;
      7:       return 5;
      8:       return 5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/math_game_bcd.sv
// Combinational 0..99 to two-digit BCD converter using a compare ladder.
module math_game_bcd (
  input  logic [6:0] i_value,
  output logic [3:0] o_tens,
  output logic [3:0] o_units
);

  always_comb begin
    o_tens  = 4'd0;
    o_units = i_value[3:0];
    for (int t = 9; t >= 1; t--) begin
      if (o_tens == 4'd0 && i_value >= 7'(t * 10)) begin
        o_tens  = 4'(t);
        o_units = 4'(i_value - 7'(t * 10));
      end
    end
  end

endmodule

// File: rtl/math_game_core.sv
// Mental-arithmetic game controller: show terms, timed answer window, verdict.
// Optional round score counter is enabled with `define MATH_GAME_SCORE_EN.
module math_game_core
  import math_game_pkg::*;
#(
  parameter int unsigned NUM_TERMS     = 5,
  parameter int unsigned TERM_W        = 5,
  parameter int unsigned SUM_MOD       = 100,
  parameter int unsigned ANSWER_CYCLES = 15,
  parameter int unsigned REVEAL_CYCLES = 4,
  parameter int unsigned LFSR_SEED     = 5'b10101,
  parameter int unsigned SW_W          = 7,
  parameter int unsigned LED_W         = 7,
  parameter bit          AUTO_RESTART  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             o_clk,
  input  logic             start,
  input  logic             op_mode,
  input  logic [SW_W-1:0]  switch,
  input  logic             submit,
  output logic [LED_W-1:0] led,
  output logic [6:0]       disp_value,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic [2:0]       phase,
  output logic             result_valid,
  output logic             result_correct,
  output logic [3:0]       score
);

  localparam int unsigned TAP    = lfsr_tap(TERM_W);
  localparam int unsigned CMP_W  = (SW_W > 7) ? SW_W : 7;
  localparam int unsigned TMR_W  = (ANSWER_CYCLES > 1) ? $clog2(ANSWER_CYCLES) : 1;
  localparam int unsigned RVL_W  = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam int unsigned LED_SH = LED_W - TERM_W;

  localparam logic [LED_W-1:0]  LED_ALL_ONES = '1;
  localparam logic [LED_W-1:0]  LED_WRONG    = LED_W'(LED_WRONG_PATTERN);
  localparam logic [TERM_W-1:0] SEED         = TERM_W'(LFSR_SEED);
  localparam logic [7:0]        MOD8         = 8'(SUM_MOD);

  phase_e              r_state;
  logic [TERM_W-1:0]   r_lfsr;
  logic [6:0]          r_sum;
  logic [3:0]          r_idx;
  logic [TMR_W-1:0]    r_timer;
  logic [RVL_W-1:0]    r_rvl;
  logic                r_mode;
  logic [LED_W-1:0]    r_led;
  logic [6:0]          r_disp;
  logic                r_valid;
  logic                r_correct;

  logic [TERM_W-1:0]   w_lfsr_next;
  logic [7:0]          w_term_ext;
  logic [7:0]          w_add;
  logic [7:0]          w_sub;
  logic [6:0]          w_add_mod;
  logic [6:0]          w_sub_mod;
  logic [6:0]          w_sum_next;
  logic [CMP_W-1:0]    w_sw_ext;
  logic [6:0]          w_sw_clamp;
  logic                w_match;
  logic                w_timer_done;
  logic                w_answer_exit;
  logic [LED_W-1:0]    w_led_cur;
  logic [LED_W-1:0]    w_led_next;

  assign w_lfsr_next = {r_lfsr[TERM_W-2:0], r_lfsr[TERM_W-1] ^ r_lfsr[TAP]};

  // Both operands stay below SUM_MOD, so one conditional correction keeps the
  // running sum in range; the extra top bit doubles as the borrow flag.
  assign w_term_ext = 8'(r_lfsr);
  assign w_add      = {1'b0, r_sum} + w_term_ext;
  assign w_sub      = {1'b0, r_sum} - w_term_ext;
  assign w_add_mod  = 7'((w_add >= MOD8) ? (w_add - MOD8) : w_add);
  assign w_sub_mod  = 7'(w_sub[7] ? (w_sub + MOD8) : w_sub);
  assign w_sum_next = (r_mode && r_idx[0]) ? w_sub_mod : w_add_mod;

  assign w_sw_ext      = CMP_W'(switch);
  assign w_sw_clamp    = (w_sw_ext[6:0] > 7'd99) ? 7'd99 : w_sw_ext[6:0];
  assign w_match       = (w_sw_ext == CMP_W'(r_sum));
  assign w_timer_done  = (r_timer == TMR_W'(ANSWER_CYCLES - 1));
  assign w_answer_exit = (r_state == PH_ANSWER) && (submit || w_timer_done);

  assign w_led_cur  = LED_W'(r_lfsr) << LED_SH;
  assign w_led_next = LED_W'(w_lfsr_next) << LED_SH;

  // Outputs are loaded on the edge entering a phase so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PH_IDLE;
      r_lfsr    <= SEED;
      r_sum     <= 7'd0;
      r_idx     <= 4'd0;
      r_timer   <= '0;
      r_rvl     <= '0;
      r_mode    <= 1'b0;
      r_led     <= '0;
      r_disp    <= 7'd0;
      r_valid   <= 1'b0;
      r_correct <= 1'b0;
    end else begin
      case (r_state)
        PH_IDLE: begin
          r_disp <= 7'd0;
          r_led  <= '0;
          if (start) begin
            r_state <= PH_SHOW;
            r_sum   <= 7'd0;
            r_idx   <= 4'd0;
            r_mode  <= op_mode;
            r_disp  <= 7'(r_lfsr);
            r_led   <= w_led_cur;
          end
        end
        PH_SHOW: begin
          r_lfsr <= w_lfsr_next;
          r_sum  <= w_sum_next;
          if (r_idx == 4'(NUM_TERMS - 1)) begin
            r_state <= PH_BLANK;
            r_idx   <= 4'd0;
            r_disp  <= 7'd0;
            r_led   <= '0;
          end else begin
            r_idx  <= r_idx + 4'd1;
            r_disp <= 7'(w_lfsr_next);
            r_led  <= w_led_next;
          end
        end
        PH_BLANK: begin
          r_state <= PH_ANSWER;
          r_timer <= '0;
          r_disp  <= w_sw_clamp;
          r_led   <= '0;
        end
        PH_ANSWER: begin
          if (w_answer_exit) begin
            r_state   <= PH_REVEAL;
            r_rvl     <= '0;
            r_valid   <= 1'b1;
            r_correct <= w_match;
            r_disp    <= r_sum;
            r_led     <= w_match ? LED_ALL_ONES : LED_WRONG;
          end else begin
            r_timer <= r_timer + 1'b1;
            r_disp  <= w_sw_clamp;
          end
        end
        PH_REVEAL: begin
          if (r_rvl == RVL_W'(REVEAL_CYCLES - 1)) begin
            r_valid <= 1'b0;
            if (AUTO_RESTART) begin
              r_state <= PH_SHOW;
              r_sum   <= 7'd0;
              r_idx   <= 4'd0;
              r_mode  <= op_mode;
              r_disp  <= 7'(r_lfsr);
              r_led   <= w_led_cur;
            end else begin
              r_state <= PH_IDLE;
              r_disp  <= 7'd0;
              r_led   <= '0;
            end
          end else begin
            r_rvl <= r_rvl + 1'b1;
          end
        end
        default: r_state <= PH_IDLE;
      endcase
    end
  end

`ifdef MATH_GAME_SCORE_EN
  logic [3:0] r_score;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= 4'd0;
    end else if (w_answer_exit && w_match && r_score != 4'd15) begin
      r_score <= r_score + 4'd1;
    end
  end

  assign score = r_score;
`else
  assign score = 4'd0;
`endif

  math_game_bcd u_bcd (
    .i_value (r_disp),
    .o_tens  (bcd_tens),
    .o_units (bcd_units)
  );

  assign o_clk          = clk;
  assign phase          = r_state;
  assign led            = r_led;
  assign disp_value     = r_disp;
  assign result_valid   = r_valid;
  assign result_correct = r_correct;

endmodule

// File: tb/tb_math_game_core.sv
// Directed bench for math_game_core: per-round expected terms and sums are
// queued at stimulus time and popped as the core shows/reveals them.
module tb_math_game_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_clk;
  logic       start = 1'b0;
  logic       op_mode = 1'b0;
  logic [6:0] switch = 7'd0;
  logic       submit = 1'b0;
  logic [6:0] led;
  logic [6:0] disp_value;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [2:0] phase;
  logic       result_valid;
  logic       result_correct;
  logic [3:0] score;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score = 0;
  logic [4:0] m_lfsr = 5'b10101;
  logic [6:0] exp_q[$];
  logic [6:0] sum_q[$];

  math_game_core dut (
    .clk            (clk),
    .rst            (rst),
    .o_clk          (o_clk),
    .start          (start),
    .op_mode        (op_mode),
    .switch         (switch),
    .submit         (submit),
    .led            (led),
    .disp_value     (disp_value),
    .bcd_tens       (bcd_tens),
    .bcd_units      (bcd_units),
    .phase          (phase),
    .result_valid   (result_valid),
    .result_correct (result_correct),
    .score          (score)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 5'b10101;
    exp_score = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_disp"}, disp_value, 0);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_valid"}, result_valid, 0);
  endtask

  // junk: submit during SHOW, start during ANSWER, and an out-of-range switch
  // value for the first ANSWER cycle to probe the 99 clamp.
  task automatic run_round(input logic mode, input bit right, input int submit_at, input bit junk);
    int s;
    int ans;
    int n_ans;
    logic [6:0] t;
    logic [6:0] exp_sum;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      t = {2'b00, m_lfsr};
      exp_q.push_back(t);
      if (mode && (k % 2 == 1)) s = s - int'(t);
      else s = s + int'(t);
      if (s >= 100) s = s - 100;
      if (s < 0) s = s + 100;
      m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    end
    sum_q.push_back(7'(s));
    ans = right ? s : (s + 1) % 100;

    start = 1'b1;
    op_mode = mode;
    switch = junk ? 7'd120 : 7'(ans);
    @(negedge clk);
    start = 1'b0;
    op_mode = ~mode;
    for (int k = 0; k < 5; k++) begin
      if (junk && k == 0) submit = 1'b1;
      t = exp_q.pop_front();
      chk("show_phase", phase, 1);
      chk("show_term", disp_value, t);
      chk("show_led", led, {t[4:0], 2'b00});
      @(negedge clk);
      submit = 1'b0;
    end
    chk("blank_phase", phase, 2);
    chk("blank_disp", disp_value, 0);
    chk("blank_led", led, 0);
    @(negedge clk);

    n_ans = 0;
    while (phase == 3'd3 && n_ans < 40) begin
      if (junk && n_ans == 0) begin
        chk("answer_clamp", disp_value, 99);
        switch = 7'(ans);
        start = 1'b1;
      end else begin
        chk("answer_disp", disp_value, ans);
        if (n_ans == 0) begin
          chk("answer_tens", bcd_tens, ans / 10);
          chk("answer_units", bcd_units, ans % 10);
        end
      end
      if (n_ans == submit_at) submit = 1'b1;
      n_ans++;
      @(negedge clk);
      submit = 1'b0;
      start = 1'b0;
    end
    chk("answer_len", n_ans, (submit_at >= 0) ? submit_at + 1 : 15);

`ifdef MATH_GAME_SCORE_EN
    if (right && exp_score < 15) exp_score++;
`endif
    exp_sum = sum_q.pop_front();
    for (int r = 0; r < 4; r++) begin
      chk("reveal_phase", phase, 4);
      chk("reveal_valid", result_valid, 1);
      chk("reveal_correct", result_correct, right);
      chk("reveal_sum", disp_value, exp_sum);
      chk("reveal_led", led, right ? 7'h7F : 7'b1010101);
      if (r == 0) begin
        chk("reveal_tens", bcd_tens, exp_sum / 10);
        chk("reveal_units", bcd_units, exp_sum % 10);
        chk("reveal_score", score, exp_score);
      end
      @(negedge clk);
    end
    check_idle_outputs("after_reveal");
  endtask

  initial begin
    // Reset state and IDLE hold without start.
    do_reset();
    check_idle_outputs("reset");
    chk("reset_correct", result_correct, 0);
    chk("reset_score", score, 0);
    chk("reset_tens", bcd_tens, 0);
    chk("reset_units", bcd_units, 0);
    repeat (3) @(negedge clk);
    chk("idle_hold", phase, 0);

    // Add mode, correct answer: terms 21,10,20,8,16, sum 75.
    run_round(1'b0, 1'b1, 2, 1'b0);

    // Same seed, alternating mode, wrong answer held until timeout: sum 39.
    do_reset();
    run_round(1'b1, 1'b0, -1, 1'b0);

    // No reseed between rounds: terms 1,2,4,9,18, sum 34.
    run_round(1'b0, 1'b1, 2, 1'b0);

    // Ignored submit in SHOW and start in ANSWER, plus switch clamp.
    run_round(1'b1, 1'b1, 2, 1'b1);

    // Reset mid-SHOW, then the next round starts from the seed again.
    start = 1'b1;
    op_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midshow_phase", phase, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 5'b10101;
    exp_score = 0;
    check_idle_outputs("midshow_rst");
    chk("midshow_score", score, 0);
    run_round(1'b0, 1'b1, 0, 1'b0);

`ifdef MATH_GAME_SCORE_EN
    for (int i = 0; i < 16; i++) run_round(1'b0, 1'b1, 0, 1'b0);
`endif
    chk("final_score", score, exp_score);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
